// File: rtl/spi_slave_sync_pkg.sv
// Shared types for the oversampling SPI slave: FSM states, pin bundles,
// edge pulses and the SPI-mode to sample-edge decode.
package spi_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_e;

  // Raw or synchronised SPI input pins.
  typedef struct packed {
    logic sclk;
    logic mosi;
    logic ss;
  } spi_pins_t;

  // Single-cycle edge pulses from the synchroniser.
  typedef struct packed {
    logic sclk_rise;
    logic sclk_fall;
    logic ss_fall;
    logic ss_rise;
  } pin_edges_t;

  // Leading edge is rising for CPOL=0, falling for CPOL=1.
  // CPHA=0 samples on leading, CPHA=1 on trailing.
  // The net effect: sampling is on the rising edge iff CPOL==CPHA.
  function automatic logic sample_on_rise(input logic cpol,
                                          input logic cpha);
    return ~(cpol ^ cpha);
  endfunction

  // The edge that is not the sample edge shifts MISO.
  function automatic logic shift_on_rise(input logic cpol,
                                         input logic cpha);
    return cpol ^ cpha;
  endfunction

endpackage

// File: rtl/spi_slave_sync_pin_sync.sv
// Synchroniser and edge detector for the SCLK/MOSI/SS pin bundle.
// Ports: clk, rst, pins_i (raw pins); ss_s, mosi_s (synced levels);
// sclk_rise, sclk_fall, ss_fall, ss_rise (one-cycle pulses).
module spi_pin_sync
  import spi_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic      clk,
  input  logic      rst,
  input  spi_pins_t pins_i,
  output logic      ss_s,
  output logic      mosi_s,
  output logic      sclk_rise,
  output logic      sclk_fall,
  output logic      ss_fall,
  output logic      ss_rise
);

  spi_pins_t [SYNC_STAGES-1:0] sync_q;
  spi_pins_t [SYNC_STAGES-1:0] sync_d;
  spi_pins_t                   lvl_q;
  spi_pins_t                   lvl_d;
  spi_pins_t                   last;
  pin_edges_t                  edges_q;
  pin_edges_t                  edges_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], pins_i};
    last   = sync_q[SYNC_STAGES-1];
    lvl_d  = last;
    edges_d.sclk_rise = last.sclk & ~lvl_q.sclk;
    edges_d.sclk_fall = ~last.sclk & lvl_q.sclk;
    edges_d.ss_fall   = ~last.ss & lvl_q.ss;
    edges_d.ss_rise   = last.ss & ~lvl_q.ss;
  end

  // The level pipeline is deliberately not reset: it keeps tracking
  // the real pins, so a reset while SS is held low does not later
  // look like a fresh SS fall.
  always_ff @(posedge clk) begin
    sync_q <= sync_d;
    lvl_q  <= lvl_d;
    if (rst) begin
      edges_q <= '0;
    end else begin
      edges_q <= edges_d;
    end
  end

  // lvl_q already holds the post-edge level in the pulse cycle.
  assign ss_s      = lvl_q.ss;
  assign mosi_s    = lvl_q.mosi;
  assign sclk_rise = edges_q.sclk_rise;
  assign sclk_fall = edges_q.sclk_fall;
  assign ss_fall   = edges_q.ss_fall;
  assign ss_rise   = edges_q.ss_rise;

endmodule

// File: rtl/spi_slave_sync.sv
// SPI slave oversampled in the clk domain, all four modes, any width.
// Ports: clk, rst, SCLK/MOSI/SS/MISO pins, rx_* and tx_* handshakes, busy.
module spi_slave_sync
  import spi_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int CPOL        = 0,
  parameter int CPHA        = 0,
  parameter int MSB_FIRST   = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  SCLK,
  input  logic                  MOSI,
  input  logic                  SS,
  output logic                  MISO,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  input  logic                  rx_ready,
  output logic                  rx_overrun,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic                  tx_underrun,
  output logic                  busy
);

  localparam int CW = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);
  localparam logic S_RISE =
    sample_on_rise(CPOL != 0, CPHA != 0);
  localparam logic H_RISE =
    shift_on_rise(CPOL != 0, CPHA != 0);

  spi_pins_t pins;
  logic ss_s;
  logic mosi_s;
  logic sclk_rise;
  logic sclk_fall;
  logic ss_fall;
  logic ss_rise;

  assign pins = '{sclk: SCLK, mosi: MOSI, ss: SS};

  spi_pin_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_pin_sync (
    .clk       (clk),
    .rst       (rst),
    .pins_i    (pins),
    .ss_s      (ss_s),
    .mosi_s    (mosi_s),
    .sclk_rise (sclk_rise),
    .sclk_fall (sclk_fall),
    .ss_fall   (ss_fall),
    .ss_rise   (ss_rise)
  );

  state_e                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] rx_sh_q, rx_sh_d;
  logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
  logic                  rx_valid_q, rx_valid_d;
  logic                  rx_ovr_q, rx_ovr_d;
  logic [DATA_WIDTH-1:0] tx_sh_q, tx_sh_d;
  logic [DATA_WIDTH-1:0] buf_q, buf_d;
  logic                  buf_full_q, buf_full_d;
  logic                  tx_unr_q, tx_unr_d;

  logic                  en;
  logic                  sample_edge;
  logic                  shift_edge;
  logic                  accept;
  logic                  load;
  logic [DATA_WIDTH-1:0] rx_word;
  logic [DATA_WIDTH-1:0] tx_shifted;

  assign sample_edge = S_RISE ? sclk_rise : sclk_fall;
  assign shift_edge  = H_RISE ? sclk_rise : sclk_fall;
  // Edges count only inside a frame with SS still low.
  assign en          = (state_q == ST_ACTIVE) && !ss_s;
  assign accept      = rx_valid_q && rx_ready;

  always_comb begin
    if (MSB_FIRST != 0) begin
      rx_word    = {rx_sh_q[DATA_WIDTH-2:0], mosi_s};
      tx_shifted = {tx_sh_q[DATA_WIDTH-2:0], 1'b0};
    end else begin
      rx_word    = {mosi_s, rx_sh_q[DATA_WIDTH-1:1]};
      tx_shifted = {1'b0, tx_sh_q[DATA_WIDTH-1:1]};
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rx_sh_d    = rx_sh_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q;
    rx_ovr_d   = 1'b0;
    tx_sh_d    = tx_sh_q;
    buf_d      = buf_q;
    buf_full_d = buf_full_q;
    tx_unr_d   = 1'b0;
    load       = 1'b0;

    if (accept) begin
      rx_valid_d = 1'b0;
    end

    if (tx_valid && !buf_full_q) begin
      buf_d      = tx_data;
      buf_full_d = 1'b1;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (ss_fall) begin
          state_d = ST_ACTIVE;
          cnt_d   = '0;
          load    = (CPHA == 0);
        end
      end
      ST_ACTIVE: begin
        if (ss_rise) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      end
    endcase

    if (en && sample_edge) begin
      rx_sh_d = rx_word;
      if (cnt_q == LAST) begin
        cnt_d      = '0;
        rx_data_d  = rx_word;
        rx_valid_d = 1'b1;
        rx_ovr_d   = rx_valid_q && !accept;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end

    // A shift edge seen at count 0 is a word boundary: for CPHA=1 it
    // is the first edge of a word, for CPHA=0 it follows the last
    // sample of the previous word. Either way it loads, not shifts.
    if (en && shift_edge) begin
      if (cnt_q == '0) begin
        load = 1'b1;
      end else begin
        tx_sh_d = tx_shifted;
      end
    end

    if (load) begin
      if (buf_full_q) begin
        tx_sh_d    = buf_q;
        buf_full_d = 1'b0;
      end else begin
        tx_sh_d  = '0;
        tx_unr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      rx_sh_q    <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      rx_ovr_q   <= 1'b0;
      tx_sh_q    <= '0;
      buf_q      <= '0;
      buf_full_q <= 1'b0;
      tx_unr_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rx_sh_q    <= rx_sh_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      rx_ovr_q   <= rx_ovr_d;
      tx_sh_q    <= tx_sh_d;
      buf_q      <= buf_d;
      buf_full_q <= buf_full_d;
      tx_unr_q   <= tx_unr_d;
    end
  end

  logic miso_bit;
  assign miso_bit = (MSB_FIRST != 0) ? tx_sh_q[DATA_WIDTH-1]
                                     : tx_sh_q[0];

  assign MISO        = en ? miso_bit : 1'bz;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign rx_overrun  = rx_ovr_q;
  assign tx_ready    = !buf_full_q;
  assign tx_underrun = tx_unr_q;
  assign busy        = (state_q == ST_ACTIVE);

endmodule

// File: doc/spi_slave_sync.md
# spi_slave_sync

Parametrised SPI slave that oversamples SCLK, MOSI and SS in the system clock domain instead of clocking logic from SCLK. Supports all four SPI modes, any word width, and back-to-back words within one SS assertion. Adds valid/ready handshakes for the receive and transmit sides, plus overrun and underrun reporting. Sits between the external SPI pins and the user logic, replacing the SCLK-clocked `spi_control`.

## Interface
Parameters:
- `DATA_WIDTH`, 8: bits per word, ≥ 2.
- `CPOL`, 0: SCLK idle level.
- `CPHA`, 0: 0 = sample on leading edge, 1 = sample on trailing edge.
- `MSB_FIRST`, 1: 1 = MSB shifted first, 0 = LSB first.
- `SYNC_STAGES`, 2: synchroniser depth on SCLK/MOSI/SS, ≥ 2.

Ports:
- `clk`  in  1  system clock; the only clock.
- `rst`  in  1  synchronous, active-high reset.
- `SCLK`  in  1  SPI clock, asynchronous to `clk`.
- `MOSI`  in  1  master data.
- `SS`  in  1  slave select, active low.
- `MISO`  out  1  slave data; `1'bz` while synchronised SS is high.
- `rx_data`  out  DATA_WIDTH  last received word.
- `rx_valid`  out  1  `rx_data` holds an unconsumed word.
- `rx_ready`  in  1  consumer accepts `rx_data`.
- `rx_overrun`  out  1  one-cycle pulse: word completed while `rx_valid` was high.
- `tx_data`  in  DATA_WIDTH  next word to send.
- `tx_valid`  in  1  `tx_data` valid.
- `tx_ready`  out  1  transmit holding buffer empty.
- `tx_underrun`  out  1  one-cycle pulse: word load with empty buffer.
- `busy`  out  1  FSM in ACTIVE.

## Operation
- **Input conditioning.** SCLK, MOSI and SS each pass through `SYNC_STAGES` flops.
- **Edge detection.** Edges are detected on synchronised SCLK.
  - Leading edge = rising if `CPOL`=0, falling if `CPOL`=1.
  - Sample edge = leading if `CPHA`=0, else trailing. Shift edge = the other one.
- **FSM states: IDLE, ACTIVE.**
  - IDLE → ACTIVE on synchronised SS falling.
  - ACTIVE → IDLE on synchronised SS rising, from any bit position.
- **Receive.**
  - On each sample edge in ACTIVE, shift MOSI into the rx shift register; bit counter increments 0..DATA_WIDTH-1, then wraps to 0.
  - On the sample edge with counter = DATA_WIDTH-1, transfer the word to `rx_data` and set `rx_valid`.
  - `rx_valid` clears on `rx_valid && rx_ready`.
  - If a word completes while `rx_valid` is still high, the new word overwrites `rx_data`, `rx_valid` stays 1, and `rx_overrun` pulses.
  - If a word completes in the same cycle as an accept, `rx_valid` stays 1 with the new word and there is no overrun.
- **Transmit buffer.** Single entry. A write is accepted when `tx_valid && tx_ready`; `tx_ready` then drops.
- **Word load.** The buffer moves into the tx shift register at the load point, and `tx_ready` rises the next cycle. If the buffer is empty, the shift register loads all zeros and `tx_underrun` pulses.
- **Load points.**
  - `CPHA`=0: on SS fall for the first word; on the shift edge after a word's final sample for later words.
  - `CPHA`=1: on the first shift edge of each word, and that edge does not shift.
- **MISO.** Driven from the shift register's MSB (`MSB_FIRST`=1) or LSB; the register shifts on other shift edges.
- **SS abort mid-word.** The partial rx word is discarded (no `rx_valid`), the counter clears, and a partially sent tx word is lost. The buffer is untouched if not yet loaded.
- **Ignored edges.** SCLK edges while SS is high are ignored.

## Timing
- **Reset values:** `rx_data`=0, `rx_valid`=0, `rx_overrun`=0, `tx_ready`=1, `tx_underrun`=0, `busy`=0, FSM=IDLE, `MISO`=z. Reset mid-frame returns to IDLE immediately; traffic resumes only after the next SS fall.
- **Receive latency:** `rx_valid` rises SYNC_STAGES+2 `clk` cycles after the physical final sample edge.
- **MISO latency:** updates SYNC_STAGES+2 cycles after the physical shift edge or SS fall.
- **Clock ratio:** `clk` ≥ 2·(SYNC_STAGES+3) × SCLK frequency (10× for default parameters). Master SS-to-first-edge delay ≥ SYNC_STAGES+3 `clk` cycles.
- **Transmit handshake:** a new `tx_data` must be written before the next load point, or an underrun occurs.

## Structure
- **Package `spi_pkg`:** FSM state encoding (IDLE, ACTIVE) and the mode-to-edge decode constants (leading/trailing, sample/shift select).
- **Sub-module `spi_pin_sync`:** the synchroniser plus edge detector, instantiated for the SCLK/SS/MOSI bundle. Outputs: synchronised levels, `sclk_rise`, `sclk_fall`, `ss_fall`, `ss_rise`.
- **Top level:** FSM, bit counter, shift registers, handshake buffers.

## Test plan
- **Mode 0, 8-bit, basic frame.** Preload tx 0xA5; master sends 0x3C. Expect `rx_data`=0x3C with one `rx_valid`, and MISO bits 1,0,1,0,0,1,0,1.
- **Mode 3, back-to-back words.** Master sends 0x12, 0x34 in one SS assertion; tx written 0xF0, then 0x0F after the first `tx_ready`. Expect rx words 0x12, 0x34 and MISO 0xF0, 0x0F, with no underrun.
- **Underrun.** No tx write; master sends 0x55. Expect MISO all 0, one `tx_underrun` pulse, and `rx_data`=0x55.
- **Overrun.** `rx_ready` held low; master sends 0x11 then 0x22. Expect one `rx_overrun` pulse and `rx_data`=0x22 with `rx_valid`=1.
- **SS abort.** SS rises after 5 bits, then a full frame 0xC3 follows. Expect no `rx_valid` for the aborted word, then `rx_data`=0xC3.
- **LSB-first and reset.** `MSB_FIRST`=0, `DATA_WIDTH`=12, `CPHA`=1: 0xABC is received correctly. Separately, `rst` mid-word gives all outputs their reset values, and the following frame works.
